// File: rtl/vga_pixel_pipeline.sv
// Pixel stage behind the VGA timing controller: framebuffer fetch, sprite overlay,
// 3:3:3 to 8:8:8 expansion and sync alignment, all with a fixed 2-clock latency.
module vga_pixel_pipeline #(
  parameter int         SPRITE_W     = 16,
  parameter int         SPRITE_H     = 16,
  parameter logic [8:0] SPRITE_COLOR = 9'b111_100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  X,
  input  logic [9:0]  Y,
  input  logic        display,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [14:0] fb_addr,
  input  logic [8:0]  fb_data,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_valid,
  output logic        sprite_ready,
  output logic [7:0]  vga_R,
  output logic [7:0]  vga_G,
  output logic [7:0]  vga_B,
  output logic        vga_HS,
  output logic        vga_VS,
  output logic        vga_blank_n,
  output logic        frame_start
);

  localparam logic [10:0] SPR_W11 = 11'(SPRITE_W);
  localparam logic [10:0] SPR_H11 = 11'(SPRITE_H);

  logic [14:0] r_fb_addr;
  logic        r_vs_prev;
  logic        r_frame_start;
  logic        r_pend_full;
  logic [9:0]  r_pend_x;
  logic [9:0]  r_pend_y;
  logic        r_sprite_en;
  logic [9:0]  r_act_x;
  logic [9:0]  r_act_y;
  logic        r_act0, r_hit0, r_hs0, r_vs0;
  logic        r_act1, r_hit1, r_hs1, r_vs1;
  logic [7:0]  r_R, r_G, r_B;
  logic        r_HS, r_VS, r_blank_n;

  logic        w_active;
  logic [14:0] w_u;
  logic [14:0] w_v;
  logic [14:0] w_addr;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_hit;
  logic        w_boundary;
  logic        w_capture;
  logic [8:0]  w_color;
  logic [7:0]  w_chan [3];

  assign w_active = display && (X < 10'd640) && (Y < 10'd480);

  // v*160 built as v*128 + v*32
  assign w_u    = {7'd0, X[9:2]};
  assign w_v    = {7'd0, Y[9:2]};
  assign w_addr = (w_v << 7) + (w_v << 5) + w_u;

  // 11-bit upper bounds clip the sprite at the right/bottom edge instead of wrapping
  assign w_x_end = {1'b0, r_act_x} + SPR_W11;
  assign w_y_end = {1'b0, r_act_y} + SPR_H11;
  assign w_hit   = r_sprite_en &&
                   (X >= r_act_x) && ({1'b0, X} < w_x_end) &&
                   (Y >= r_act_y) && ({1'b0, Y} < w_y_end);

  assign w_boundary   = r_vs_prev && !vs_in;
  assign sprite_ready = !r_pend_full;
  assign w_capture    = sprite_valid && !r_pend_full;

  always_comb begin
    w_color = 9'd0;
    if (r_act1) begin
      w_color = r_hit1 ? SPRITE_COLOR : fb_data;
    end
  end

  // channel 2 = R (bits 8:6), 1 = G, 0 = B
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_expand
      assign w_chan[gi] = {w_color[3*gi+2 -: 3], w_color[3*gi+2 -: 3], w_color[3*gi+2 -: 2]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fb_addr     <= 15'd0;
      r_vs_prev     <= 1'b0;
      r_frame_start <= 1'b0;
      r_pend_full   <= 1'b0;
      r_pend_x      <= 10'd0;
      r_pend_y      <= 10'd0;
      r_sprite_en   <= 1'b0;
      r_act_x       <= 10'd0;
      r_act_y       <= 10'd0;
      r_act0        <= 1'b0;
      r_hit0        <= 1'b0;
      r_hs0         <= 1'b1;
      r_vs0         <= 1'b1;
      r_act1        <= 1'b0;
      r_hit1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_R           <= 8'd0;
      r_G           <= 8'd0;
      r_B           <= 8'd0;
      r_HS          <= 1'b1;
      r_VS          <= 1'b1;
      r_blank_n     <= 1'b0;
    end else begin
      r_vs_prev     <= vs_in;
      r_frame_start <= w_boundary;

      if (w_active) begin
        r_fb_addr <= w_addr;
      end

      r_act0 <= w_active;
      r_hit0 <= w_active && w_hit;
      r_hs0  <= hs_in;
      r_vs0  <= vs_in;

      r_act1 <= r_act0;
      r_hit1 <= r_hit0;
      r_hs1  <= r_hs0;
      r_vs1  <= r_vs0;

      r_R       <= w_chan[2];
      r_G       <= w_chan[1];
      r_B       <= w_chan[0];
      r_HS      <= r_hs1;
      r_VS      <= r_vs1;
      r_blank_n <= r_act1;

      // Capture only happens with an empty slot, commit only with a full one,
      // so a same-cycle capture waits for the following boundary.
      if (w_capture) begin
        r_pend_x    <= sprite_x;
        r_pend_y    <= sprite_y;
        r_pend_full <= 1'b1;
      end
      if (w_boundary && r_pend_full) begin
        r_act_x     <= r_pend_x;
        r_act_y     <= r_pend_y;
        r_sprite_en <= 1'b1;
        r_pend_full <= 1'b0;
      end
    end
  end

  assign fb_addr     = r_fb_addr;
  assign frame_start = r_frame_start;
  assign vga_R       = r_R;
  assign vga_G       = r_G;
  assign vga_B       = r_B;
  assign vga_HS      = r_HS;
  assign vga_VS      = r_VS;
  assign vga_blank_n = r_blank_n;

endmodule

// File: doc/vga_pixel_pipeline.md
# vga_pixel_pipeline

Downstream stage of the VGA timing controller. It consumes the controller's `X`/`Y`/`display`/`vga_HS`/`vga_VS` stream and turns it into the RGB pixels and aligned sync signals for the DAC. Each pixel is read from a 160x120 downscaled framebuffer in external synchronous RAM, and one rectangular drone sprite is overlaid on top. The sprite position is written through a valid/ready handshake and takes effect only at frame boundaries, so a frame never shows a torn sprite.

## Interface
- `SPRITE_W`, default 16: sprite width in screen pixels (1..640).
- `SPRITE_H`, default 16: sprite height in screen pixels (1..480).
- `SPRITE_COLOR`, default 9'b111_100_000: sprite colour as a 3:3:3 RGB value.
- `clk`  in  1: pixel clock, the same clock as the timing controller.
- `reset`  in  1: reset, synchronous, active-high.
- `X`  in  10: horizontal pixel coordinate from the timing controller.
- `Y`  in  10: vertical pixel coordinate from the timing controller.
- `display`  in  1: the timing controller's active-video flag.
- `hs_in`  in  1: horizontal sync from the timing controller, active-low.
- `vs_in`  in  1: vertical sync from the timing controller, active-low.
- `fb_addr`  out  15: framebuffer read address, word address 0..19199.
- `fb_data`  in  9: framebuffer word {R[2:0],G[2:0],B[2:0]}; valid one clock after `fb_addr`.
- `sprite_x`  in  10: new sprite left edge.
- `sprite_y`  in  10: new sprite top edge.
- `sprite_valid`  in  1: the new sprite position is offered.
- `sprite_ready`  out  1: the pending slot is empty and can accept a position.
- `vga_R`  out  8: red channel to the DAC.
- `vga_G`  out  8: green channel to the DAC.
- `vga_B`  out  8: blue channel to the DAC.
- `vga_HS`  out  1: horizontal sync, delayed to align with the pixel outputs.
- `vga_VS`  out  1: vertical sync, delayed to align with the pixel outputs.
- `vga_blank_n`  out  1: high when the output pixel is active video.
- `frame_start`  out  1: one-clock pulse at each detected frame boundary.

## Operation
- **Active region.** A pixel is active when `display`=1, X<640 and Y<480. In every other case the pixel is blank.
- **Address generation.** For each input pixel, u=X>>2 and v=Y>>2, and fb_addr = (v<<7)+(v<<5)+u. The sum is computed at 15 bits with no multiplier. For blank pixels, `fb_addr` holds its previous value.
- **Sprite hit.** A pixel hits the sprite when sprite_en=1, act_x ≤ X < act_x+SPRITE_W and act_y ≤ Y < act_y+SPRITE_H. The upper bounds are compared at 11 bits, so a sprite near the right or bottom edge is clipped and never wraps to column or row 0.
- **Pixel select.** The output colour c is:
  - 0 if the pixel is blank;
  - SPRITE_COLOR if the pixel is active and hits the sprite;
  - `fb_data` otherwise.
- **Channel expansion.** Each 3-bit channel value c expands to 8 bits as {c,c,c[2:1]}. For example, 3'b111 gives 8'hFF and 3'b100 gives 8'h92.
- **Frame boundary.** A frame boundary is the cycle in which `vs_in` is seen falling (previous sample 1, current sample 0). `frame_start` pulses in the cycle after detection, registered.
- **Sprite handshake.**
  - Registers: a pending slot {pend_full, pend_x, pend_y} and an active set {sprite_en, act_x, act_y}.
  - `sprite_ready` = !pend_full.
  - When `sprite_valid` and `sprite_ready` are both high at a clock edge, the slot captures `sprite_x`/`sprite_y` and pend_full is set.
  - At a frame boundary with pend_full=1, the active set loads from the pending slot, sprite_en is set and pend_full is cleared.
  - While pend_full=1, `sprite_valid` is ignored. The producer must hold its data until the transfer completes.
- **Capture and boundary in the same cycle.** The commit uses the pending contents from before that edge.
  - If the slot was empty, the value captured in that cycle waits for the next boundary.
  - If the slot was full, `sprite_ready` was 0, so no capture happens.
- **Reset.** Reset can be asserted at any point in a frame. It clears all pipeline registers, pend_full and sprite_en, and also act_x/act_y, the previous `vs_in` sample, `fb_addr` and `frame_start`. After reset:
  - the outputs are blank and `vga_HS`=`vga_VS`=1;
  - the first boundary seen after reset takes effect normally.

## Timing
- Pipeline stage 0 (edge N): the inputs are sampled, `fb_addr` is registered, the sprite hit is computed, and the active flag, hit flag and syncs are registered.
- Pipeline stage 1 (edge N+1): the RAM returns data, which the block samples at edge N+2.
- Output (edge N+2): RGB, `vga_blank_n`, `vga_HS` and `vga_VS` are registered. The total latency from input to output is exactly 2 clocks for every output.
- The sync delay equals the pixel delay, so the timing controller's sync-to-video relationship is preserved.
- Reset values of the outputs:
  - `vga_R`/`vga_G`/`vga_B` = 0, `vga_blank_n` = 0;
  - `vga_HS` = 1, `vga_VS` = 1;
  - `fb_addr` = 0, `frame_start` = 0;
  - `sprite_ready` = 1 (combinational from pend_full).
- A position written in frame F becomes visible in the first frame whose boundary occurs after the capture. The earliest visible pixel follows 2 clocks after the position has been committed.
- Throughput is one pixel per clock, with no stalls.

## Test plan
- **Address mapping:** with display=1, drive (X,Y)=(0,0), (3,3), (4,0), (639,479) and (5,9). `fb_addr` must read 0, 0, 1, 19199 and 321, each one clock after the input.
- **Latency and expansion:** with the RAM model returning 9'b111_000_100 and no sprite committed, drive an active pixel at cycle N. At cycle N+2 the outputs must be R=FF, G=00, B=92 with `vga_blank_n`=1, and `vga_HS`/`vga_VS` must equal the inputs from cycle N.
- **Blanking:** display=0, or display=1 with X=700, must give RGB=0 and `vga_blank_n`=0 two clocks later. `fb_addr` must stay unchanged.
- **Handshake:**
  - Write (100,50) mid-frame: `sprite_ready` must fall the next cycle.
  - A second write of (200,60) while the slot is full must be ignored.
  - At the next `vs_in` fall: `frame_start` must pulse, `sprite_ready` must return to 1, pixel (100,50) must show SPRITE_COLOR, pixel (116,50) must show framebuffer data, and (200,60) must never appear.
- **Clipping:** a committed sprite at (630,475) with a 16x16 size must hit at (639,479) and must not hit at (0,475) or (630,0).
- **Reset mid-frame:** assert reset during active video with a sprite committed. The outputs must read blank with HS=VS=1, `sprite_ready` must be 1, and the sprite must be absent until a new write is committed.
